// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder. On an accepted start the operands and carry-in
//   are latched, then one bit per clock is pushed LSB-first through a single
//   FullAdderStructure cell. The carry is kept in a flop between bits. The sum
//   is assembled by shifting each cell sum bit in at the MSB. The final carry
//   is captured on the last bit edge. Completion is signalled by a one-cycle
//   done pulse.
//
//   Parameters
//     WIDTH  operand/sum width in bits (>= 1)
//
//   Ports
//     ck     in   clock, all state updates on posedge
//     rst    in   asynchronous active-high reset
//     start  in   request, sampled only while idle
//     a, b   in   operands, latched on an accepted start
//     cin    in   carry-in, latched on an accepted start
//     busy   out  high while bits are being processed
//     done   out  one-cycle pulse, sum/cout valid
//     sum    out  registered result, held until the next accepted start
//     cout   out  registered final carry, held with sum
//
// FullAdderStructure
//   One-bit full adder cell (port order x, y, cin, cout, s).
// -----------------------------------------------------------------------------

module FullAdderStructure (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic cout,
  output logic s
);

  logic p;

  assign p    = x ^ y;
  assign s    = p ^ cin;
  assign cout = (x & y) | (cin & p);

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter must hold 0..WIDTH; never narrower than one bit.
  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic             fa_s;
  logic             fa_cout;
  logic             last_bit;
  logic [WIDTH:0]   sum_cat;

  FullAdderStructure u_fa (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .cin  (carry),
    .cout (fa_cout),
    .s    (fa_s)
  );

  assign last_bit = (cnt == LAST);

  // Concatenate-then-slice keeps the MSB insertion legal for WIDTH == 1.
  assign sum_cat = {fa_s, sum};

  // State register
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, straight from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shift registers, carry flop, bit counter, result
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum   <= sum_cat[WIDTH:1];
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            cout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;

  // WIDTH = 8 instance
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  // WIDTH = 1 instance
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  // WIDTH = 4 instance
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .ck(ck), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .ck(ck), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );
  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .ck(ck), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  // Drives one addition on the 8-bit instance and observes it. done_at is the
  // index of the cycle (0 = cycle right after the accepting edge) where done
  // was seen, -1 on timeout. Operands are scrambled once accepted.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                      output int done_at, output int busy_n, output bit overlap,
                      output logic [7:0] rs, output logic rc);
    @(posedge ck); #1;
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    @(posedge ck); #1;
    start8 = 1'b0; a8 = ~ia; b8 = ~ib; cin8 = ~ic;
    done_at = -1; busy_n = 0; overlap = 1'b0;
    for (int i = 0; i < 16 && done_at < 0; i++) begin
      @(negedge ck);
      if (busy8) busy_n++;
      if (busy8 && done8) overlap = 1'b1;
      if (done8) done_at = i;
    end
    rs = sum8; rc = cout8;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
    start1 = 0; a1 = '0; b1 = '0; cin1 = 0;
    start4 = 0; a4 = '0; b4 = '0; cin4 = 0;
    #2;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done8); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", sum8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout8); end
    repeat (2) @(negedge ck);
    rst = 1'b0;
    @(negedge ck);
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b done %b expected 0 0", busy8, done8); end
  endtask

  task automatic test_basic;
    int d, bn; bit ov; logic [7:0] s; logic c;
    run8(8'h5A, 8'h3C, 1'b0, d, bn, ov, s, c);
    checks++; if (d != 8) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 8", d); end
    checks++; if (bn != 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bn); end
    checks++; if (ov) begin errors++; $display("FAIL basic_overlap: busy and done high together"); end
    checks++; if (s !== 8'h96) begin errors++; $display("FAIL basic_sum: got %h expected 96", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", c); end
    @(negedge ck);
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done8); end
    repeat (3) @(negedge ck);
    checks++; if (sum8 !== 8'h96 || busy8 !== 1'b0) begin errors++; $display("FAIL basic_hold: sum %h busy %b expected 96 0", sum8, busy8); end
  endtask

  task automatic test_carry;
    int d, bn; bit ov; logic [7:0] s; logic c;
    run8(8'hFF, 8'h01, 1'b0, d, bn, ov, s, c);
    checks++; if ({c, s} !== 9'h100) begin errors++; $display("FAIL carry_ff_01: got %b_%h expected 1_00", c, s); end
    run8(8'hFF, 8'hFF, 1'b1, d, bn, ov, s, c);
    checks++; if ({c, s} !== 9'h1FF) begin errors++; $display("FAIL carry_ff_ff_1: got %b_%h expected 1_ff", c, s); end
  endtask

  task automatic test_start_while_busy;
    int dones = 0;
    logic [7:0] s_at = 'x;
    logic c_at = 1'bx;
    @(posedge ck); #1;
    a8 = 8'h10; b8 = 8'h20; cin8 = 0; start8 = 1;
    @(posedge ck); #1;
    start8 = 0;
    repeat (2) @(posedge ck);
    #1;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1; start8 = 1;
    @(posedge ck); #1;
    start8 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ck);
      if (done8) begin dones++; s_at = sum8; c_at = cout8; end
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", dones); end
    checks++; if ({c_at, s_at} !== 9'h030) begin errors++; $display("FAIL busy_start_result: got %b_%h expected 0_30", c_at, s_at); end
  endtask

  task automatic test_reset_mid_op;
    int d, bn; bit ov; logic [7:0] s; logic c;
    run8(8'hFF, 8'hFF, 1'b1, d, bn, ov, s, c);
    @(posedge ck); #1;
    a8 = 8'hFF; b8 = 8'h00; cin8 = 0; start8 = 1;
    @(posedge ck); #1;
    start8 = 0;
    repeat (4) @(posedge ck);
    #1 rst = 1'b1;
    #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done8); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL midreset_sum: got %h expected 00", sum8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL midreset_cout: got %b expected 0", cout8); end
    @(negedge ck);
    rst = 1'b0;
    run8(8'h01, 8'h01, 1'b1, d, bn, ov, s, c);
    checks++; if (d != 8) begin errors++; $display("FAIL midreset_after_done: got %0d expected 8", d); end
    checks++; if ({c, s} !== 9'h003) begin errors++; $display("FAIL midreset_after_sum: got %b_%h expected 0_03", c, s); end
  endtask

  task automatic test_exhaustive_w1;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      int got;
      vv = 3'(v);
      @(posedge ck); #1;
      cin1 = vv[2]; a1 = vv[1]; b1 = vv[0]; start1 = 1;
      @(posedge ck); #1;
      start1 = 0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      got = -1;
      for (int i = 0; i < 8 && got < 0; i++) begin
        @(negedge ck);
        if (done1) got = i;
      end
      checks++;
      if (got != 1) begin
        errors++; $display("FAIL w1_done_cycle v=%0d: got %0d expected 1", v, got);
      end
      checks++;
      if ({cout1, sum1} !== (2'(vv[2]) + 2'(vv[1]) + 2'(vv[0]))) begin
        errors++; $display("FAIL w1_sum v=%0d: got %b%b expected %0d", v, cout1, sum1, vv[2] + vv[1] + vv[0]);
      end
    end
  endtask

  task automatic test_exhaustive_w4;
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      logic [4:0] exp;
      bit got;
      vv = 9'(v);
      exp = 5'(vv[7:4]) + 5'(vv[3:0]) + 5'(vv[8]);
      @(posedge ck); #1;
      cin4 = vv[8]; a4 = vv[7:4]; b4 = vv[3:0]; start4 = 1;
      @(posedge ck); #1;
      start4 = 0; a4 = 4'($urandom); b4 = 4'($urandom);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge ck);
        if (done4) got = 1;
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL w4_timeout v=%0d: no done within 10 cycles", v);
      end else if ({cout4, sum4} !== exp) begin
        errors++; $display("FAIL w4_sum v=%0d: got %h expected %h", v, {cout4, sum4}, exp);
      end
    end
  endtask

  task automatic test_random;
    int d, bn; bit ov; logic [7:0] s; logic c;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra, rb;
      logic rc;
      logic [8:0] exp;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = 9'(ra) + 9'(rb) + 9'(rc);
      run8(ra, rb, rc, d, bn, ov, s, c);
      checks++;
      if (d != 8 || bn != 8 || ov) begin
        errors++; $display("FAIL random_timing n=%0d: done_at %0d busy %0d overlap %0d expected 8 8 0", n, d, bn, ov);
      end
      checks++;
      if ({c, s} !== exp) begin
        errors++; $display("FAIL random_sum n=%0d a=%h b=%h cin=%b: got %h expected %h", n, ra, rb, rc, {c, s}, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ha [0:70];
    logic [7:0] hb [0:70];
    logic       hc [0:70];
    int ndone = 0;
    @(negedge ck);
    ha[0] = 8'($urandom); hb[0] = 8'($urandom); hc[0] = 1'($urandom);
    a8 = ha[0]; b8 = hb[0]; cin8 = hc[0]; start8 = 1;
    for (int e = 0; e < 60; e++) begin
      bit exp_done, exp_busy;
      @(posedge ck); #1;
      ha[e+1] = 8'($urandom); hb[e+1] = 8'($urandom); hc[e+1] = 1'($urandom);
      a8 = ha[e+1]; b8 = hb[e+1]; cin8 = hc[e+1];
      @(negedge ck);
      exp_done = (e >= 8) && ((e - 8) % 10 == 0);
      exp_busy = (e % 10) < 8;
      checks++;
      if (busy8 && done8) begin
        errors++; $display("FAIL b2b_overlap e=%0d: busy and done both high", e);
      end
      checks++;
      if (done8 !== exp_done || busy8 !== exp_busy) begin
        errors++; $display("FAIL b2b_timing e=%0d: done %b busy %b expected %b %b", e, done8, busy8, exp_done, exp_busy);
      end
      if (done8 && e >= 8) begin
        logic [8:0] exp;
        exp = 9'(ha[e-8]) + 9'(hb[e-8]) + 9'(hc[e-8]);
        ndone++;
        checks++;
        if ({cout8, sum8} !== exp) begin
          errors++; $display("FAIL b2b_sum e=%0d: got %h expected %h", e, {cout8, sum8}, exp);
        end
      end
    end
    start8 = 0;
    checks++;
    if (ndone != 6) begin errors++; $display("FAIL b2b_done_count: got %0d expected 6", ndone); end
    repeat (12) @(posedge ck);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_start_while_busy;
    test_reset_mid_op;
    test_exhaustive_w1;
    test_exhaustive_w4;
    test_random;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
